// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Latches the decoded control bundle, operands, immediate, PC and register
// addresses for EX, and detects load-use hazards against the instruction
// currently in ID.
// Optional feature: define ID_EX_PERF_EN to add BubbleCnt/FlushCnt counters.
//
// Control bundle packing, MSB first:
//   [17] RegWrite  [16] MemWrite  [15:11] ALUOp  [10:8] NPCOp  [7] ALUSrc
//   [6:5] WDSel    [4:3] GPRSel   [2:0] DMType
// An all-zero bundle is a harmless bubble (no write, no store, NPCOp=PLUS4).
//
// Handshake: there is no valid/ready pair here. Stall is a combinational
// request to upstream (PC, IF/ID) to hold this cycle; Hold is a global freeze
// from downstream; Flush kills whatever would enter EX on this edge.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [XLEN-1:0]   ID_RD1,
  input  logic [XLEN-1:0]   ID_RD2,
  input  logic [XLEN-1:0]   ID_Imm,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [RA_W-1:0]   ID_rs1,
  input  logic [RA_W-1:0]   ID_rs2,
  input  logic [RA_W-1:0]   ID_rd,
  input  logic              ID_Valid,
  input  logic              Flush,
  input  logic              Hold,
  output logic              Stall,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [XLEN-1:0]   EX_RD1,
  output logic [XLEN-1:0]   EX_RD2,
  output logic [XLEN-1:0]   EX_Imm,
  output logic [XLEN-1:0]   EX_PC,
  output logic [RA_W-1:0]   EX_rs1,
  output logic [RA_W-1:0]   EX_rs2,
  output logic [RA_W-1:0]   EX_rd,
  output logic              EX_Valid
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       BubbleCnt,
  output logic [31:0]       FlushCnt
`endif
);

  // WDSel position inside the control bundle; 2'b01 selects memory data (load)
  localparam int          WDSEL_LO = 5;
  localparam logic [1:0]  WD_MEM   = 2'b01;

  logic [1:0] ex_wdsel;
  logic       ex_is_load;
  logic       rs_match;
  logic       take_bubble;
  logic       load_en;

  assign ex_wdsel = EX_Ctrl[WDSEL_LO+1:WDSEL_LO];

  // Load-use hazard: a load in EX whose rd (never x0) feeds the ID instruction
  always_comb begin
    ex_is_load = EX_Valid && (ex_wdsel == WD_MEM) && (EX_rd != '0);
    rs_match   = (EX_rd == ID_rs1) || (EX_rd == ID_rs2);
    Stall      = rstn && !Flush && ex_is_load && ID_Valid && rs_match;
  end

  // Edge decision: Flush beats Hold; Hold freezes; a stall or an empty ID slot
  // captures a bubble; otherwise the ID instruction moves into EX
  always_comb begin
    take_bubble = Flush || (!Hold && (Stall || !ID_Valid));
    load_en     = Flush || !Hold;
  end

  // Pipeline register; the bubble value is all-zero on every field
  always_ff @(posedge clk) begin
    if (!rstn || (load_en && take_bubble)) begin
      EX_Ctrl  <= '0;
      EX_RD1   <= '0;
      EX_RD2   <= '0;
      EX_Imm   <= '0;
      EX_PC    <= '0;
      EX_rs1   <= '0;
      EX_rs2   <= '0;
      EX_rd    <= '0;
      EX_Valid <= 1'b0;
    end else if (load_en) begin
      EX_Ctrl  <= ID_Ctrl;
      EX_RD1   <= ID_RD1;
      EX_RD2   <= ID_RD2;
      EX_Imm   <= ID_Imm;
      EX_PC    <= ID_PC;
      EX_rs1   <= ID_rs1;
      EX_rs2   <= ID_rs2;
      EX_rd    <= ID_rd;
      EX_Valid <= ID_Valid;
    end
  end

`ifdef ID_EX_PERF_EN
  logic bubble_evt;
  assign bubble_evt = Stall && !Hold;

  // Saturating event counters. A Flush overrides Hold, so a flush taken under
  // Hold still counts; a stall bubble cannot enter while Hold is high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      BubbleCnt <= '0;
      FlushCnt  <= '0;
    end else begin
      if (bubble_evt && (BubbleCnt != 32'hFFFF_FFFF)) BubbleCnt <= BubbleCnt + 32'd1;
      if (Flush && (FlushCnt != 32'hFFFF_FFFF))       FlushCnt  <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model of the
// EX slot. Define ID_EX_PERF_EN to also check the event counters.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [17:0] ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } ex_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [17:0] id_ctrl;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_valid, flush, hold;

  logic        stall;
  logic [17:0] ex_ctrl;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_valid;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rstn(rstn),
    .ID_Ctrl(id_ctrl), .ID_RD1(id_rd1), .ID_RD2(id_rd2), .ID_Imm(id_imm),
    .ID_PC(id_pc), .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_rd(id_rd),
    .ID_Valid(id_valid), .Flush(flush), .Hold(hold),
    .Stall(stall), .EX_Ctrl(ex_ctrl), .EX_RD1(ex_rd1), .EX_RD2(ex_rd2),
    .EX_Imm(ex_imm), .EX_PC(ex_pc), .EX_rs1(ex_rs1), .EX_rs2(ex_rs2),
    .EX_rd(ex_rd), .EX_Valid(ex_valid)
`ifdef ID_EX_PERF_EN
    , .BubbleCnt(bubble_cnt), .FlushCnt(flush_cnt)
`endif
  );

  // ---------------- reference model ----------------
  ex_t         m;            // what the EX slot should hold
  logic [31:0] m_bubbles, m_flushes;
  int          n_checks = 0;
  int          n_fail   = 0;

  // A load sits in EX and its non-zero destination is read by the ID instruction
  function automatic logic exp_stall();
    return rstn && !flush && m.valid && (m.ctrl[6:5] == 2'b01) && (m.rd != 0)
           && id_valid && ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  function automatic ex_t id_slot();
    ex_t t;
    t = '{ctrl: id_ctrl, rd1: id_rd1, rd2: id_rd2, imm: id_imm, pc: id_pc,
          rs1: id_rs1, rs2: id_rs2, rd: id_rd, valid: 1'b1};
    return t;
  endfunction

  // Advance the model by one clock edge using the priority rules
  task automatic tick();
    logic st;
    @(posedge clk);
    st = exp_stall();
    if (!rstn) begin
      m = '0; m_bubbles = 0; m_flushes = 0;
    end else if (flush) begin
      m = '0;
      if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
    end else if (hold) begin
      m = m;
    end else if (st) begin
      m = '0;
      if (m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
    end else if (id_valid) begin
      m = id_slot();
    end else begin
      m = '0;
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic check(string tag);
    #1;
    n_checks++;
    assert (ex_ctrl === m.ctrl) else begin
      n_fail++; $error("FAIL %s.ctrl got %h exp %h", tag, ex_ctrl, m.ctrl);
    end
    n_checks++;
    assert ({ex_rd1, ex_rd2, ex_imm, ex_pc} === {m.rd1, m.rd2, m.imm, m.pc}) else begin
      n_fail++; $error("FAIL %s.data got %h %h %h %h exp %h %h %h %h", tag,
                       ex_rd1, ex_rd2, ex_imm, ex_pc, m.rd1, m.rd2, m.imm, m.pc);
    end
    n_checks++;
    assert ({ex_rs1, ex_rs2, ex_rd} === {m.rs1, m.rs2, m.rd}) else begin
      n_fail++; $error("FAIL %s.addr got %h %h %h exp %h %h %h", tag,
                       ex_rs1, ex_rs2, ex_rd, m.rs1, m.rs2, m.rd);
    end
    n_checks++;
    assert (ex_valid === m.valid) else begin
      n_fail++; $error("FAIL %s.valid got %b exp %b", tag, ex_valid, m.valid);
    end
    n_checks++;
    assert (stall === exp_stall()) else begin
      n_fail++; $error("FAIL %s.stall got %b exp %b", tag, stall, exp_stall());
    end
`ifdef ID_EX_PERF_EN
    n_checks++;
    assert ({bubble_cnt, flush_cnt} === {m_bubbles, m_flushes}) else begin
      n_fail++; $error("FAIL %s.cnt got %0d/%0d exp %0d/%0d", tag,
                       bubble_cnt, flush_cnt, m_bubbles, m_flushes);
    end
`endif
  endtask

  // Directed check against a fixed expectation
  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++; $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(logic [17:0] c, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, logic [31:0] imm, logic v);
    id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm;
    id_valid = v;
    id_rd1 = $urandom; id_rd2 = $urandom; id_pc = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic drive_random();
    id_ctrl = 18'($urandom);
    if ($urandom_range(0, 1) == 1) id_ctrl[6:5] = 2'b01;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_rd  = 5'($urandom_range(0, 3));
    id_valid = ($urandom_range(0, 9) < 8);
  endtask

  // {RegWrite,MemWrite,ALUOp,NPCOp,ALUSrc,WDSel,GPRSel,DMType}
  localparam logic [17:0] C_ADDI = {1'b1, 1'b0, 5'd1, 3'd0, 1'b1, 2'b00, 2'b00, 3'd0};
  localparam logic [17:0] C_LW   = {1'b1, 1'b0, 5'd1, 3'd0, 1'b1, 2'b01, 2'b00, 3'd2};
  localparam logic [17:0] C_ADD  = {1'b1, 1'b0, 5'd1, 3'd0, 1'b0, 2'b00, 2'b00, 3'd0};

  // ---------------- directed + random sequence ----------------
  initial begin
    m = '0; m_bubbles = 0; m_flushes = 0;
    rstn = 1'b0; flush = 1'b0; hold = 1'b0;
    @(negedge clk);

    // 1: reset with random inputs
    drive_random(); flush = 1'($urandom); hold = 1'($urandom);
    tick();
    drive_random();
    tick();
    check("reset");
    expect_eq("reset_valid", {31'd0, ex_valid}, 32'd0);
    expect_eq("reset_stall", {31'd0, stall}, 32'd0);
    rstn = 1'b1; flush = 1'b0; hold = 1'b0;

    // 2: addi x5,x0,7
    drive(C_ADDI, 5'd0, 5'd0, 5'd5, 32'd7, 1'b1);
    check("addi_id");
    tick();
    check("addi_ex");
    expect_eq("addi_imm", ex_imm, 32'd7);
    expect_eq("addi_rd", {27'd0, ex_rd}, 32'd5);
    expect_eq("addi_ctrl", {14'd0, ex_ctrl}, {14'd0, C_ADDI});

    // 3: lw x3 then add x4,x3,x1 -> one-cycle stall, bubble, then add
    drive(C_LW, 5'd2, 5'd0, 5'd3, 32'd16, 1'b1);
    tick();
    drive(C_ADD, 5'd3, 5'd1, 5'd4, 32'd0, 1'b1);
    check("lu_stall");
    expect_eq("lu_stall_hi", {31'd0, stall}, 32'd1);
    tick();
    check("lu_bubble");
    expect_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    expect_eq("lu_stall_lo", {31'd0, stall}, 32'd0);
    tick();
    check("lu_add");
    expect_eq("lu_add_rd", {27'd0, ex_rd}, 32'd4);

    // 4: load to x0 never stalls
    drive(C_LW, 5'd2, 5'd0, 5'd0, 32'd4, 1'b1);
    tick();
    drive(C_ADD, 5'd0, 5'd1, 5'd4, 32'd0, 1'b1);
    check("x0_nostall");
    expect_eq("x0_stall_lo", {31'd0, stall}, 32'd0);
    tick();
    check("x0_add");
    expect_eq("x0_add_valid", {31'd0, ex_valid}, 32'd1);

    // 5: Flush and Hold together with a valid ID
    drive(C_ADDI, 5'd1, 5'd2, 5'd6, 32'd9, 1'b1);
    flush = 1'b1; hold = 1'b1;
    check("flush_hold_pre");
    tick();
    flush = 1'b0; hold = 1'b0;
    check("flush_hold");
    expect_eq("flush_ctrl", {14'd0, ex_ctrl}, 32'd0);
`ifdef ID_EX_PERF_EN
    expect_eq("flush_cnt", flush_cnt, 32'd1);
`endif

    // 6: Hold for 3 cycles over a pending load-use hazard
    drive(C_LW, 5'd2, 5'd0, 5'd3, 32'd8, 1'b1);
    tick();
    drive(C_ADD, 5'd1, 5'd3, 5'd4, 32'd0, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_hazard");
      expect_eq("hold_stall", {31'd0, stall}, 32'd1);
      expect_eq("hold_rd", {27'd0, ex_rd}, 32'd3);
      tick();
    end
    hold = 1'b0;
    check("hold_release");
    tick();
    check("hold_bubble");
    expect_eq("hold_bubble_valid", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_EN
    expect_eq("bubble_cnt", bubble_cnt, 32'd2);
`endif
    tick();
    check("hold_add");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_random();
      rstn  = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      check("rand_pre");
      tick();
    end
    rstn = 1'b1; flush = 1'b0; hold = 1'b0;
    check("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
